// File: rtl/arm_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle ARM sequencing controller.
package arm_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_FAULT
  } state_e;

  // Instr[27:26] instruction class
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_UND = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  localparam logic [1:0] RS_NORM = 2'b00;
  localparam logic [1:0] RS_BR   = 2'b01;
  localparam logic [1:0] RS_STR  = 2'b10;

  // Instr[24:21] data-processing cmd values that are supported
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam int WCNT_W = 4;

  // Control fields latched in DECODE and held until the instruction commits
  typedef struct packed {
    logic [1:0] op;
    logic       load;
    logic       alu_src;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
    logic [1:0] alu_ctrl;
  } ctl_t;

endpackage

// File: rtl/arm_decoder.sv
// Purely combinational instruction decoder: Instr -> control fields + unsupported flag.
module arm_decoder
  import arm_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output ctl_t        ctl,
  output logic        unsupported
);

  // Condition field and register/offset fields are handled by the datapath.
  logic unused_bits;
  assign unused_bits = ^{instr[31:28], instr[19:0]};

  // Map the instruction class and sub-fields onto datapath controls
  always_comb begin
    ctl         = '0;
    unsupported = 1'b0;
    ctl.op      = instr[27:26];
    case (instr[27:26])
      OP_DP: begin
        ctl.alu_src = instr[25];
        ctl.imm_src = IMM_DP;
        ctl.reg_src = RS_NORM;
        case (instr[24:21])
          CMD_ADD: ctl.alu_ctrl = ALU_ADD;
          CMD_SUB: ctl.alu_ctrl = ALU_SUB;
          CMD_AND: ctl.alu_ctrl = ALU_AND;
          CMD_ORR: ctl.alu_ctrl = ALU_ORR;
          default: unsupported  = 1'b1;
        endcase
      end
      OP_MEM: begin
        ctl.load     = instr[20];
        ctl.alu_src  = 1'b1;
        ctl.imm_src  = IMM_MEM;
        // U bit selects add or subtract of the offset
        ctl.alu_ctrl = instr[23] ? ALU_ADD : ALU_SUB;
        // STR reads the store data register through the Rd read port
        ctl.reg_src  = instr[20] ? RS_NORM : RS_STR;
      end
      OP_BR: begin
        ctl.alu_src  = 1'b0;
        ctl.imm_src  = IMM_BR;
        ctl.reg_src  = RS_BR;
        ctl.alu_ctrl = ALU_ADD;
      end
      default: unsupported = 1'b1;
    endcase
  end

endmodule

// File: rtl/arm_seq_ctrl.sv
// Multi-cycle sequencing controller: fetch/decode/execute/memory FSM with
// bounded ready-wait handling and a sticky fault state.
module arm_seq_ctrl
  import arm_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Instr,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUControl,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic        MemtoReg,
  output logic        PCSrc,
  output logic        MemWrite,
  output logic        PCEn,
  output logic        IRWrite,
  output logic        fault
);

  localparam logic [WCNT_W-1:0] TIMEOUT_CNT = WCNT_W'(MEM_TIMEOUT);

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [WCNT_W-1:0] wait_inc;
  ctl_t              ctl_q, ctl_d;
  ctl_t              dec_ctl;
  logic              dec_unsupported;

  arm_decoder u_decoder (
    .instr       (Instr),
    .ctl         (dec_ctl),
    .unsupported (dec_unsupported)
  );

  // Next state, wait counter and latched decode fields
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    ctl_d      = ctl_q;
    // wait_inc is the number of not-ready cycles including the current one,
    // so the timeout fires on the MEM_TIMEOUT-th consecutive waiting cycle
    // and a ready in that same cycle still wins.
    wait_inc   = wait_cnt_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        state_d    = ST_FETCH;
        wait_cnt_d = '0;
      end
      ST_FETCH: begin
        if (imem_ready) begin
          state_d = ST_DECODE;
        end else begin
          wait_cnt_d = wait_inc;
          if (wait_inc == TIMEOUT_CNT) state_d = ST_FAULT;
        end
      end
      ST_DECODE: begin
        ctl_d      = dec_ctl;
        wait_cnt_d = '0;
        if (dec_unsupported)          state_d = ST_FAULT;
        else if (dec_ctl.op == OP_MEM) state_d = ST_MEM;
        else                           state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d    = ST_FETCH;
        wait_cnt_d = '0;
      end
      ST_MEM: begin
        if (dmem_ready) begin
          state_d    = ST_FETCH;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_inc;
          if (wait_inc == TIMEOUT_CNT) state_d = ST_FAULT;
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FAULT;
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      ctl_q      <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      ctl_q      <= ctl_d;
    end
  end

  // Output decode from state and latched fields; only fetch handshake and
  // MEM commit strobes look at the ready inputs
  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    RegSrc     = '0;
    ImmSrc     = '0;
    ALUControl = '0;
    RegWrite   = 1'b0;
    ALUSrc     = 1'b0;
    MemtoReg   = 1'b0;
    PCSrc      = 1'b0;
    MemWrite   = 1'b0;
    PCEn       = 1'b0;
    IRWrite    = 1'b0;
    fault      = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        IRWrite  = imem_ready;
      end
      ST_EXEC: begin
        RegSrc     = ctl_q.reg_src;
        ImmSrc     = ctl_q.imm_src;
        ALUControl = ctl_q.alu_ctrl;
        ALUSrc     = ctl_q.alu_src;
        PCEn       = 1'b1;
        RegWrite   = (ctl_q.op == OP_DP);
        PCSrc      = (ctl_q.op == OP_BR);
      end
      ST_MEM: begin
        RegSrc     = ctl_q.reg_src;
        ImmSrc     = ctl_q.imm_src;
        ALUControl = ctl_q.alu_ctrl;
        ALUSrc     = ctl_q.alu_src;
        dmem_req   = 1'b1;
        dmem_we    = ~ctl_q.load;
        // Mux select held for the whole access so the datapath sees it stable
        MemtoReg   = ctl_q.load;
        if (dmem_ready) begin
          PCEn     = 1'b1;
          MemWrite = ~ctl_q.load;
          RegWrite = ctl_q.load;
        end
      end
      ST_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

endmodule
